// File: rtl/lfsr_prbs_check.sv
// Self-synchronising PRBS checker for the parallel word stream of the lfsr generator.
// Optional build macro LFSR_PRBS_CHECK_BIT_ERR_EN: err_count accumulates bit errors instead of errored words.
module lfsr_prbs_check #(
  parameter int                    LFSR_WIDTH   = 9,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 9'h021,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    LOCK_COUNT   = 16,
  parameter int                    UNLOCK_COUNT = 4,
  parameter int                    CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  input  logic                  clear,
  output logic                  locked,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int SEED_WORDS = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int SEED_W     = $clog2(SEED_WORDS + 1);
  localparam int GOOD_W     = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W      = $clog2(UNLOCK_COUNT + 1);
  localparam int INC_W      = $clog2(DATA_WIDTH + 1);
  localparam int SUM_W      = CNT_WIDTH + 1;

  typedef enum logic [1:0] {
    SEED,
    HUNT,
    LOCKED
  } state_e;

  state_e                state_q;
  logic [LFSR_WIDTH-1:0] history_q;
  logic [LFSR_WIDTH-1:0] history_d;
  logic [SEED_W-1:0]     seedCnt_q;
  logic [GOOD_W-1:0]     goodCnt_q;
  logic [BAD_W-1:0]      badCnt_q;
  logic                  locked_q;
  logic                  error_q;
  logic [CNT_WIDTH-1:0]  errCount_q;
  logic [CNT_WIDTH-1:0]  wordCount_q;

  logic [LFSR_WIDTH-1:0] predShift;
  logic [LFSR_WIDTH-1:0] rcvShift;
  logic                  feedback;
  logic [DATA_WIDTH-1:0] expWord;
  logic                  mismatch;
  logic [INC_W-1:0]      errInc;
  logic [SUM_W-1:0]      errSum;
  logic [CNT_WIDTH-1:0]  errSat;
  logic [CNT_WIDTH-1:0]  wordSat;

  // History keeps the oldest bit at index 0 and the newest at the MSB. The
  // prediction chain runs only on expected bits, while the next history is
  // built from the received bits, which is what makes the checker resync.
  always_comb begin
    predShift = history_q;
    rcvShift  = history_q;
    feedback  = 1'b0;
    expWord   = '0;
    for (int j = DATA_WIDTH - 1; j >= 0; j--) begin
      feedback   = ^(predShift & LFSR_POLY);
      expWord[j] = feedback;
      predShift  = {feedback, predShift[LFSR_WIDTH-1:1]};
      rcvShift   = {data_in[j], rcvShift[LFSR_WIDTH-1:1]};
    end
    history_d = rcvShift;
  end

  // An all-zero history would predict all zeros forever, so it never counts as a match.
  assign mismatch = (data_in != expWord) || (history_q == '0);

`ifdef LFSR_PRBS_CHECK_BIT_ERR_EN
  logic [DATA_WIDTH-1:0] diffBits;
  logic [INC_W-1:0]      bitErrs;

  assign diffBits = data_in ^ expWord;

  // A zero-guard mismatch can have no differing bits; still charge one error.
  always_comb begin
    bitErrs = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      bitErrs = bitErrs + INC_W'(diffBits[i]);
    end
    errInc = (bitErrs == '0) ? INC_W'(1) : bitErrs;
  end
`else
  assign errInc = INC_W'(1);
`endif

  assign errSum  = {1'b0, errCount_q} + SUM_W'(errInc);
  assign errSat  = errSum[CNT_WIDTH] ? '1 : errSum[CNT_WIDTH-1:0];
  assign wordSat = (&wordCount_q) ? wordCount_q : wordCount_q + CNT_WIDTH'(1);

  // Checker FSM with registered status outputs. Clear is applied last so it
  // overrides any increment made by the same word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEED;
      history_q   <= '0;
      seedCnt_q   <= '0;
      goodCnt_q   <= '0;
      badCnt_q    <= '0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      errCount_q  <= '0;
      wordCount_q <= '0;
    end else begin
      error_q <= 1'b0;
      if (data_in_valid) begin
        history_q <= history_d;
        case (state_q)
          SEED: begin
            if (seedCnt_q == SEED_W'(SEED_WORDS - 1)) begin
              state_q   <= HUNT;
              seedCnt_q <= '0;
              goodCnt_q <= '0;
            end else begin
              seedCnt_q <= seedCnt_q + SEED_W'(1);
            end
          end
          HUNT: begin
            if (mismatch) begin
              goodCnt_q <= '0;
            end else if (goodCnt_q == GOOD_W'(LOCK_COUNT - 1)) begin
              state_q   <= LOCKED;
              locked_q  <= 1'b1;
              goodCnt_q <= '0;
              badCnt_q  <= '0;
            end else begin
              goodCnt_q <= goodCnt_q + GOOD_W'(1);
            end
          end
          LOCKED: begin
            wordCount_q <= wordSat;
            if (mismatch) begin
              error_q    <= 1'b1;
              errCount_q <= errSat;
              if (badCnt_q == BAD_W'(UNLOCK_COUNT - 1)) begin
                state_q   <= HUNT;
                locked_q  <= 1'b0;
                badCnt_q  <= '0;
                goodCnt_q <= '0;
              end else begin
                badCnt_q <= badCnt_q + BAD_W'(1);
              end
            end else begin
              badCnt_q <= '0;
            end
          end
          default: begin
            state_q <= SEED;
          end
        endcase
      end
      if (clear) begin
        errCount_q  <= '0;
        wordCount_q <= '0;
      end
    end
  end

  assign locked     = locked_q;
  assign error      = error_q;
  assign err_count  = errCount_q;
  assign word_count = wordCount_q;

endmodule

// File: doc/lfsr_prbs_check.md
# lfsr_prbs_check

PRBS checker sitting directly downstream of the `lfsr` PRBS generator. It consumes a parallel PRBS word stream, self-synchronises to it from the received bits, and reports lock status and error counts. It is used on loopback and link bring-up paths to qualify the PRBS9 (or other polynomial) pattern produced upstream.

## Interface
- `LFSR_WIDTH`, 9: LFSR state width.
- `LFSR_POLY`, 9'h021: feedback polynomial, Fibonacci form, same encoding as `lfsr` (PRBS9 = x^9+x^5+1).
- `DATA_WIDTH`, 8: bits per input word.
- `LOCK_COUNT`, 16: consecutive error-free words needed to declare lock (≥1).
- `UNLOCK_COUNT`, 4: consecutive errored words that drop lock (≥1).
- `CNT_WIDTH`, 32: width of the saturating counters.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  DATA_WIDTH  received word; bit DATA_WIDTH-1 is earliest in time.
- `data_in_valid`  in  1  word qualifier; no backpressure.
- `clear`  in  1  synchronous clear of both counters.
- `locked`  out  1  checker is in LOCKED.
- `error`  out  1  one-cycle pulse: last checked word mismatched.
- `err_count`  out  CNT_WIDTH  saturating error counter.
- `word_count`  out  CNT_WIDTH  saturating count of words checked while locked.

## Operation
- History register holds the last LFSR_WIDTH received bits. Expected word = next DATA_WIDTH sequence bits predicted from history via LFSR_POLY, computed bit-serially within the word from history and earlier expected bits, not from received bits of the same word.
- After each valid word, history shifts in the received bits, never the expected ones. The checker is therefore self-synchronising.
- States:
  - SEED: after reset. Accept ceil(LFSR_WIDTH/DATA_WIDTH) valid words into history, unchecked. Then go to HUNT with the good counter at 0.
  - HUNT: each valid word is compared with the expected word. A match increments the good counter; a mismatch clears it. On reaching LOCK_COUNT, go to LOCKED. Zero-lock guard: a word checked while history is all-zero counts as a mismatch.
  - LOCKED: each valid word increments `word_count`. A mismatch pulses `error`, adds to `err_count`, and increments the bad counter; a match clears the bad counter. On reaching UNLOCK_COUNT, go to HUNT with the good counter cleared.
- In HUNT and SEED, `error` stays low and the counters hold.
- Counters saturate at all-ones.
- `clear` takes priority over increment in the same cycle: the counters become 0 and that word's increment is dropped. `clear` does not affect state.
- Cycles with `data_in_valid` low change nothing.

## Timing
- Reset values: `locked`=0, `error`=0, `err_count`=0, `word_count`=0, history=0, state SEED, internal counters 0.
- All outputs are registered. A word presented with valid in cycle N is reflected in `error`, the counters and `locked` in cycle N+1.
- `locked` rises in the cycle after the LOCK_COUNT-th good word. It falls in the cycle after the UNLOCK_COUNT-th consecutive bad word; that word is still counted and still pulses `error`.
- Reset asserted mid-stream returns everything to reset values immediately. Reseeding needs fresh SEED words.
- Back-to-back valid words are supported at one word per clock.

## Configuration
- `LFSR_PRBS_CHECK_BIT_ERR_EN`:
  - Defined: `err_count` adds popcount(received XOR expected) per word, saturating. The add must clamp; it must not wrap.
  - Undefined: `err_count` adds 1 per mismatched word, and no popcount logic is built.
  - `error` behaviour is identical in both cases.

## Test plan
- Clean PRBS9 stream, seed 9'h1FF, 8 bits/word, valid every cycle. Expect: 2 SEED words, then 16 HUNT words; `locked`=1 one cycle after word 18; `err_count`=0; `word_count` equals the number of words after lock.
- Locked, then flip bit 0 of one word. Expect: one `error` pulse and `err_count`=1 with or without the macro; lock held. Flip 3 bits in one word: `err_count` +3 with the macro, +1 without.
- Locked, then inject 4 consecutive all-ones words. Expect: `locked` falls after the 4th, `err_count` +4 (word mode). Resume clean PRBS: relock after 16 good words.
- All-zero input for 100 words. Expect: `locked` stays 0 and `error` is never asserted (zero-lock guard).
- Set CNT_WIDTH=4 and lock, then corrupt 20 words spaced by 2 good words. Expect: `err_count` saturates at 4'hF. Assert `clear` on a corrupted word: count is 0 the next cycle.
- Deassert `rst_n` mid-lock, with `data_in_valid` toggling randomly. Expect: immediate reset values, and relock after 2+16 valid words with gaps ignored.
